// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types, constants and round-robin pick function for the mux4_rr_arbiter slice.
package mux4_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT
  } state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Walk from the farthest candidate toward ptr+1 so the nearest asserted index overwrites the result.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req, input logic [SEL_W-1:0] ptr);
    pick_t            res;
    logic [SEL_W-1:0] cand;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Bus between the four sources/sink (master side) and the arbiter (slave side).
interface mux4_rr_arbiter_if #(
  parameter int W = 1
);
  import mux4_arb_pkg::*;

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*W-1:0] din;
  logic [NUM_REQ-1:0]   gnt;
  logic [SEL_W-1:0]     sel;
  logic                 busy;
  logic [W-1:0]         dout;
  logic                 dout_vld;

  modport master (
    output req, din,
    input  gnt, sel, busy, dout, dout_vld
  );

  modport slave (
    input  req, din,
    output gnt, sel, busy, dout, dout_vld
  );

endinterface

// File: rtl/mux4_rr_arbiter_sel_path.sv
// Decoder-based W-bit 4:1 mux with an enable gate so the output is zero when nothing is granted.
module mux4_sel_path
  import mux4_arb_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [NUM_REQ*W-1:0] din_i,
  input  logic [SEL_W-1:0]     sel_i,
  input  logic                 en_i,
  output logic [W-1:0]         dout_o
);

  logic [NUM_REQ-1:0] dec;

  always_comb begin
    dec         = '0;
    dec[sel_i]  = 1'b1;
    dout_o      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dout_o = dout_o | (din_i[i*W +: W] & {W{dec[i]}});
    end
    dout_o = dout_o & {W{en_i}};
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin 4-way arbiter with bounded bursts driving a shared 4:1 mux.
// Define MUXARB_OUT_REG_EN to register dout/dout_vld (one extra cycle of latency).
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int W         = 1,
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst_n,
  mux4_rr_arbiter_if.slave bus
);

  localparam int                CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_BURST - 1);

  state_e             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [SEL_W-1:0]   sel_q;
  logic               busy_q;
  logic [SEL_W-1:0]   ptr_q;
  logic [CNT_W-1:0]   cnt_q;

  pick_t              pick_d;
  logic               take_d;
  logic               drop_d;
  logic               own_req;
  logic               other_req;
  logic               expired;

  assign pick_d    = rr_pick(bus.req, ptr_q);
  assign own_req   = bus.req[sel_q];
  assign other_req = |(bus.req & ~gnt_q);
  assign expired   = (cnt_q == CNT_LAST);

  // Release takes precedence over expiry; either hands off only when someone else is waiting.
  always_comb begin
    take_d = 1'b0;
    drop_d = 1'b0;
    case (state_q)
      IDLE: take_d = pick_d.found;
      GRANT: begin
        if (!own_req) begin
          take_d = other_req;
          drop_d = !other_req;
        end else if (expired) begin
          take_d = other_req;
        end
      end
      default: begin
        take_d = 1'b0;
        drop_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= SEL_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else if (take_d) begin
      state_q <= GRANT;
      gnt_q   <= NUM_REQ'(1) << pick_d.idx;
      sel_q   <= pick_d.idx;
      busy_q  <= 1'b1;
      ptr_q   <= pick_d.idx;
      cnt_q   <= '0;
    end else if (drop_d) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (state_q == GRANT) begin
      cnt_q   <= expired ? '0 : cnt_q + 1'b1;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;

  logic [W-1:0] mux_out;

  mux4_sel_path #(
    .W(W)
  ) u_sel_path (
    .din_i (bus.din),
    .sel_i (sel_q),
    .en_i  (busy_q),
    .dout_o(mux_out)
  );

`ifdef MUXARB_OUT_REG_EN
  logic [W-1:0] dout_q;
  logic         vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      dout_q <= mux_out;
      vld_q  <= busy_q;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = vld_q;
`else
  assign bus.dout     = mux_out;
  assign bus.dout_vld = busy_q;
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: W=8 with MAX_BURST=4 (dut0) and MAX_BURST=1 (dut1).
module tb_mux4_rr_arbiter;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mux4_rr_arbiter_if #(.W(W)) bus0 ();
  mux4_rr_arbiter_if #(.W(W)) bus1 ();

  mux4_rr_arbiter #(.W(W), .MAX_BURST(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mux4_rr_arbiter #(.W(W), .MAX_BURST(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int          total = 0;
  int          bad   = 0;
  logic [15:0] expQ[$];
  logic [15:0] prev;
  logic [15:0] obs0;
  logic [15:0] obs1;

  assign obs0 = {bus0.gnt, bus0.sel, bus0.busy, bus0.dout, bus0.dout_vld};
  assign obs1 = {bus1.gnt, bus1.sel, bus1.busy, bus1.dout, bus1.dout_vld};

  // Expected {gnt, sel, busy, dout, dout_vld} for an unregistered output stage.
  function automatic logic [15:0] combExp(input logic [3:0] g, input logic [31:0] d);
    int        s;
    logic      b;
    logic [7:0] o;
    s = 0;
    for (int i = 0; i < 4; i++) if (g[i]) s = i;
    b = |g;
    o = b ? d[s*8 +: 8] : 8'h00;
    return {g, 2'(s), b, o, b};
  endfunction

  function automatic logic [15:0] finalExp(input logic [15:0] c);
`ifdef MUXARB_OUT_REG_EN
    return {c[15:9], prev[8:0]};
`else
    return c;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n    = 1'b0;
    bus0.req = 4'b0000;
    bus1.req = 4'b0000;
    prev     = '0;
    #7;
    rst_n    = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    bus0.req = 4'b1111;
    bus1.req = 4'b1111;
    #1;
    total++;
    if (obs0 !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL reset_dut0: got %h expected %h", obs0, 16'h0000);
    end
    total++;
    if (obs1 !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL reset_dut1: got %h expected %h", obs1, 16'h0000);
    end
    doReset();
    tick();
    total++;
    if (obs0 !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL idle_no_req: got %h expected %h", obs0, 16'h0000);
    end
  endtask

  task automatic test_single_hold();
    logic [15:0] e;
    doReset();
    bus0.din = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    bus0.req = 4'b0001;
    for (int k = 0; k < 10; k++) expQ.push_back(combExp(4'b0001, bus0.din));
    while (expQ.size() > 0) begin
      tick();
      e = expQ.pop_front();
      total++;
      if (obs0 !== finalExp(e)) begin
        bad++;
        $display("[TB] FAIL single_hold: got %h expected %h", obs0, finalExp(e));
      end
      prev = e;
    end
    bus0.req = 4'b0000;
    for (int k = 0; k < 2; k++) expQ.push_back(combExp(4'b0000, bus0.din));
    while (expQ.size() > 0) begin
      tick();
      e = expQ.pop_front();
      total++;
      if (obs0 !== finalExp(e)) begin
        bad++;
        $display("[TB] FAIL drop_to_idle: got %h expected %h", obs0, finalExp(e));
      end
      prev = e;
    end
  endtask

  task automatic test_rotation();
    logic [15:0] e;
    logic [3:0]  g;
    doReset();
    bus0.din = 32'h44332211;
    bus0.req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      g = 4'b0001 << ((k / 4) % 4);
      expQ.push_back(combExp(g, bus0.din));
    end
    while (expQ.size() > 0) begin
      tick();
      e = expQ.pop_front();
      total++;
      if (obs0 !== finalExp(e)) begin
        bad++;
        $display("[TB] FAIL rotation: got %h expected %h", obs0, finalExp(e));
      end
      prev = e;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    logic [3:0]  reqs [5] = '{4'b0100, 4'b0101, 4'b0001, 4'b0001, 4'b0000};
    logic [3:0]  gnts [5] = '{4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b0000};
    doReset();
    for (int k = 0; k < 5; k++) begin
      bus0.req = reqs[k];
      bus0.din = $urandom;
      expQ.push_back(combExp(gnts[k], bus0.din));
      tick();
      e = expQ.pop_front();
      total++;
      if (obs0 !== finalExp(e)) begin
        bad++;
        $display("[TB] FAIL back_to_back: got %h expected %h", obs0, finalExp(e));
      end
      prev = e;
    end
  endtask

  task automatic test_midburst_reset();
    logic [15:0] e;
    doReset();
    bus0.din = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    bus0.req = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      expQ.push_back(combExp(4'b0001, bus0.din));
      tick();
      e = expQ.pop_front();
      total++;
      if (obs0 !== finalExp(e)) begin
        bad++;
        $display("[TB] FAIL pre_reset_burst: got %h expected %h", obs0, finalExp(e));
      end
      prev = e;
    end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs0 !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL async_reset: got %h expected %h", obs0, 16'h0000);
    end
    prev     = '0;
    bus0.req = 4'b1010;
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) expQ.push_back(combExp(4'b0010, bus0.din));
    expQ.push_back(combExp(4'b1000, bus0.din));
    while (expQ.size() > 0) begin
      tick();
      e = expQ.pop_front();
      total++;
      if (obs0 !== finalExp(e)) begin
        bad++;
        $display("[TB] FAIL post_reset_order: got %h expected %h", obs0, finalExp(e));
      end
      prev = e;
    end
  endtask

  task automatic test_owner2_data();
    logic [15:0] e;
    doReset();
    bus0.din = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    bus0.req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      expQ.push_back(combExp(4'b0100, bus0.din));
      tick();
      e = expQ.pop_front();
      total++;
      if (obs0 !== finalExp(e)) begin
        bad++;
        $display("[TB] FAIL owner2_data: got %h expected %h", obs0, finalExp(e));
      end
      prev = e;
    end
  endtask

  task automatic test_burst1();
    logic [15:0] e;
    doReset();
    bus1.din = 32'h0;
    bus1.req = 4'b0101;
    for (int k = 0; k < 8; k++) expQ.push_back(combExp((k % 2 == 0) ? 4'b0001 : 4'b0100, bus1.din));
    while (expQ.size() > 0) begin
      tick();
      e = expQ.pop_front();
      total++;
      if (obs1[15:9] !== e[15:9]) begin
        bad++;
        $display("[TB] FAIL burst1_alternate: got %h expected %h", obs1[15:9], e[15:9]);
      end
    end
    bus1.req = 4'b0000;
  endtask

  initial begin
    rst_n    = 1'b0;
    prev     = '0;
    bus0.req = 4'b0000;
    bus0.din = '0;
    bus1.req = 4'b0000;
    bus1.din = '0;
    #2;
    test_reset();
    test_single_hold();
    test_rotation();
    test_back_to_back();
    test_midburst_reset();
    test_owner2_data();
    test_burst1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
